// File: rtl/tick_period_meter_if.sv
// Bundle of the tick_period_meter control, input and result signals.
//
// Signals:
//   ce     - count enable; the meter advances only in cycles with ce=1
//   clr    - synchronous clear of the measurement, qualified by ce
//   sig    - asynchronous signal whose period is measured
//   period - last completed measurement, in ce cycles
//   valid  - one-cycle strobe: period updated this cycle
//   ovf    - sticky: counter saturated with no edge seen
//   busy   - meter is in the MEASURE state
//
// Modports:
//   master - drives ce/clr/sig and observes the results (status logic, bench)
//   slave  - the meter itself
interface tick_period_meter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ce;
  logic             clr;
  logic             sig;
  logic [WIDTH-1:0] period;
  logic             valid;
  logic             ovf;
  logic             busy;

  modport master (
    output ce,
    output clr,
    output sig,
    input  period,
    input  valid,
    input  ovf,
    input  busy
  );

  modport slave (
    input  ce,
    input  clr,
    input  sig,
    output period,
    output valid,
    output ovf,
    output busy
  );
endinterface

// File: rtl/tick_period_meter.sv
// Measures the period of a slow toggling input in enabled (ce) clock cycles.
//
// The input is brought through a SYNC_STAGES-deep synchronizer, an edge is
// detected against the previous synchronized sample, and a counter runs
// between consecutive qualifying edges. Each completed period is published
// as a registered value with a one-cycle valid strobe. A sticky overflow
// flag reports an input that stopped toggling long enough for the counter
// to saturate.
//
// Parameters:
//   WIDTH       - width of the period counter and the period result
//   SYNC_STAGES - synchronizer depth on sig (2..4)
//   EDGE_MODE   - 0: rising-to-rising, 1: between any two consecutive edges
//
// Ports:
//   clk_i  - system clock, all flops on its rising edge
//   rst_ni - asynchronous active-low reset
//   bus_io - slave side of tick_period_meter_if (ce, clr, sig in;
//            period, valid, ovf, busy out)
module tick_period_meter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0
) (
  input logic                clk_i,
  input logic                rst_ni,
  tick_period_meter_if.slave bus_io
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("tick_period_meter: SYNC_STAGES must be 2..4");
  end
  if (EDGE_MODE > 1) begin : g_bad_mode
    $error("tick_period_meter: EDGE_MODE must be 0 or 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("tick_period_meter: WIDTH must be at least 1");
  end

  localparam bit EdgeAny = (EDGE_MODE != 0);

  typedef enum logic {
    StIdle,
    StMeasure
  } state_e;

  // Input synchronizer and edge history.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sig_s;
  logic                   sig_edge;

  // Measurement state.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  // One bit wider than the counter so the saturation case is visible
  // instead of silently wrapping to zero.
  logic [WIDTH:0]   cnt_inc;
  logic             cnt_max;

  assign sig_s    = sync_q[SYNC_STAGES-1];
  assign sig_edge = EdgeAny ? (sig_s ^ hist_q) : (sig_s & ~hist_q);

  assign cnt_inc  = {1'b0, cnt_q} + (WIDTH + 1)'(1);
  assign cnt_max  = &cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    if (bus_io.ce) begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (bus_io.clr) begin
            ovf_d    = 1'b0;
            period_d = '0;
          end else if (sig_edge) begin
            // First edge only arms the measurement; no result yet.
            state_d = StMeasure;
          end
        end

        StMeasure: begin
          if (bus_io.clr) begin
            state_d  = StIdle;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            period_d = '0;
          end else if (sig_edge) begin
            // An edge on the saturation cycle still reports, clamped to the
            // largest representable value, and flags the overflow.
            period_d = cnt_inc[WIDTH] ? '1 : cnt_inc[WIDTH-1:0];
            valid_d  = 1'b1;
            cnt_d    = '0;
            if (cnt_max) begin
              ovf_d = 1'b1;
            end
          end else if (cnt_max) begin
            // Input stopped toggling: give up and wait for a fresh first edge.
            ovf_d   = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[WIDTH-1:0];
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // The synchronizer only shifts in enabled cycles, so sig is sampled
      // at the ce rate and the edge history tracks ce cycles.
      if (bus_io.ce) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus_io.sig};
        hist_q <= sig_s;
      end
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus_io.period = period_q;
  assign bus_io.valid  = valid_q;
  assign bus_io.ovf    = ovf_q;
  assign bus_io.busy   = (state_q == StMeasure);

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: three instances share one clock,
// reset and stimulus (8-bit rising-edge, 8-bit any-edge, 4-bit rising-edge).
module tb_tick_period_meter;

  logic clk;
  logic rst_n;

  int unsigned n_checks;
  int unsigned n_errors;

  tick_period_meter_if #(.WIDTH(8)) if_w8 ();
  tick_period_meter_if #(.WIDTH(8)) if_w8e ();
  tick_period_meter_if #(.WIDTH(4)) if_w4 ();

  tick_period_meter #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(0)) u_w8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (if_w8)
  );

  tick_period_meter #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(1)) u_w8e (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (if_w8e)
  );

  tick_period_meter #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_MODE(0)) u_w4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (if_w4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic clr, input logic sig);
    if_w8.ce   = ce;
    if_w8.clr  = clr;
    if_w8.sig  = sig;
    if_w8e.ce  = ce;
    if_w8e.clr = clr;
    if_w8e.sig = sig;
    if_w4.ce   = ce;
    if_w4.clr  = clr;
    if_w4.sig  = sig;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  logic exp_v;
  logic exp_ve;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state.
    do_reset();
    check("rst_period", if_w8.period, 0);
    check("rst_valid", if_w8.valid, 0);
    check("rst_ovf", if_w8.ovf, 0);
    check("rst_busy", if_w8.busy, 0);

    // 10-clock square wave, ce=1. Rising edges at steps 0,10,...; each is
    // acted on 3 clocks later, so results appear at steps 12,22,...
    // Any-edge mode sees an edge every 5 steps, first result at step 7.
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 1'b0, (i % 10) < 5);
      tick();
      exp_v  = (i >= 12) && ((i - 12) % 10 == 0);
      exp_ve = (i >= 7) && ((i - 7) % 5 == 0);
      check("sq_valid", if_w8.valid, exp_v);
      if (exp_v) check("sq_period", if_w8.period, 10);
      check("sq_any_valid", if_w8e.valid, exp_ve);
      if (exp_ve) check("sq_any_period", if_w8e.period, 5);
    end
    check("sq_ovf", if_w8.ovf, 0);
    check("sq_busy", if_w8.busy, 1);

    // Same square wave, ce every other cycle: period is 5 ce cycles.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive((i % 2) == 0, 1'b0, (i % 10) < 5);
      tick();
      exp_v = (i >= 14) && ((i - 14) % 10 == 0);
      check("ce_valid", if_w8.valid, exp_v);
      if (exp_v) check("ce_period", if_w8.period, 5);
    end

    // 4-bit meter: one measurement, then sig stays low until saturation.
    do_reset();
    for (int i = 0; i < 29; i++) begin
      drive(1'b1, 1'b0, (i < 2) || (i == 10) || (i == 11));
      tick();
      if (i == 12) begin
        check("ovf_meas_valid", if_w4.valid, 1);
        check("ovf_meas_period", if_w4.period, 10);
      end
      if (i == 27) begin
        check("ovf_pre_ovf", if_w4.ovf, 0);
        check("ovf_pre_busy", if_w4.busy, 1);
      end
      if (i == 28) begin
        check("ovf_set", if_w4.ovf, 1);
        check("ovf_busy_drop", if_w4.busy, 0);
        check("ovf_period_kept", if_w4.period, 10);
        check("ovf_no_valid", if_w4.valid, 0);
        check("ovf_w8_clear", if_w8.ovf, 0);
      end
    end
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("clr_ovf", if_w4.ovf, 0);
    check("clr_period", if_w4.period, 0);
    check("clr_busy", if_w4.busy, 0);

    // Edge on the saturation cycle: 16-step spacing on the 4-bit meter
    // clamps to 15 and flags overflow; the 8-bit meter reports 16.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, (i < 2) || (i == 16) || (i == 17));
      tick();
      if (i == 17) begin
        check("sat_pre_valid", if_w4.valid, 0);
        check("sat_pre_ovf", if_w4.ovf, 0);
      end
      if (i == 18) begin
        check("sat_valid", if_w4.valid, 1);
        check("sat_period", if_w4.period, 15);
        check("sat_ovf", if_w4.ovf, 1);
        check("sat_busy", if_w4.busy, 1);
        check("sat_w8_period", if_w8.period, 16);
        check("sat_w8_ovf", if_w8.ovf, 0);
      end
      if (i == 19) begin
        check("sat_ovf_sticky", if_w4.ovf, 1);
        check("sat_valid_once", if_w4.valid, 0);
      end
    end

    // clr on the same cycle as a qualifying edge in MEASURE.
    do_reset();
    for (int i = 0; i < 44; i++) begin
      drive(1'b1, i == 22, (i % 10) < 5);
      tick();
      if (i == 12) begin
        check("ce_clr_first_valid", if_w8.valid, 1);
        check("ce_clr_first_period", if_w8.period, 10);
      end
      if (i == 22) begin
        check("edge_clr_valid", if_w8.valid, 0);
        check("edge_clr_period", if_w8.period, 0);
        check("edge_clr_busy", if_w8.busy, 0);
      end
      if (i == 32) begin
        check("edge_clr_rearm_valid", if_w8.valid, 0);
        check("edge_clr_rearm_busy", if_w8.busy, 1);
      end
      if (i == 42) begin
        check("edge_clr_next_valid", if_w8.valid, 1);
        check("edge_clr_next_period", if_w8.period, 10);
      end
    end

    // Asynchronous reset pulse mid-period.
    do_reset();
    for (int i = 0; i < 44; i++) begin
      if (i == 28) rst_n = 1'b1;
      drive(1'b1, 1'b0, (i % 10) < 5);
      tick();
      if (i == 22) begin
        check("arst_pre_valid", if_w8.valid, 1);
        check("arst_pre_period", if_w8.period, 10);
      end
      if (i == 25) begin
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_period", if_w8.period, 0);
        check("arst_busy", if_w8.busy, 0);
        check("arst_valid", if_w8.valid, 0);
        check("arst_ovf", if_w8.ovf, 0);
      end
      if (i == 26) check("arst_hold_busy", if_w8.busy, 0);
      if (i == 32) begin
        check("arst_rearm_valid", if_w8.valid, 0);
        check("arst_rearm_busy", if_w8.busy, 1);
        check("arst_rearm_period", if_w8.period, 0);
      end
      if (i == 42) begin
        check("arst_next_valid", if_w8.valid, 1);
        check("arst_next_period", if_w8.period, 10);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
